// File: rtl/buffer_sched_pkg.sv
// Shared types for the buffer read scheduler: FSM encoding, read-tag layout
// and the requester-ID decoder.
package buffer_sched_pkg;

    localparam int MAX_REQ = 16;
    localparam int ID_W    = 4;

    localparam logic [0:0] S_IDLE  = 1'b0;
    localparam logic [0:0] S_ISSUE = 1'b1;

    typedef enum logic [0:0] {
        IDLE  = S_IDLE,
        ISSUE = S_ISSUE
    } state_t;

    typedef struct packed {
        logic            vld;
        logic [ID_W-1:0] id;
        logic            last;
    } tag_t;

    function automatic logic [MAX_REQ-1:0] onehot(input logic [ID_W-1:0] id);
        return MAX_REQ'(1) << id;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: first requester at or after ptr_i, modulo
// NUM_REQ, returned both one-hot and as an index.
module rr_arbiter
    import buffer_sched_pkg::*;
#(
    parameter int NUM_REQ = 3
) (
    input  logic [NUM_REQ-1:0] req_i,
    input  logic [ID_W-1:0]    ptr_i,
    output logic [NUM_REQ-1:0] grant_o,
    output logic [ID_W-1:0]    idx_o,
    output logic               any_o
);

    // NOTE: every output of a combinational block gets a default before any
    // branch, so no path leaves it unassigned and no latch is inferred.
    always_comb begin
        grant_o = '0;
        idx_o   = '0;
        any_o   = |req_i;
        // Scan from the furthest candidate back to ptr_i so the nearest one wins.
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            if (req_i[(int'(ptr_i) + k) % NUM_REQ]) begin
                grant_o                                 = '0;
                grant_o[(int'(ptr_i) + k) % NUM_REQ]    = 1'b1;
                idx_o                                   = ID_W'((int'(ptr_i) + k) % NUM_REQ);
            end
        end
    end

endmodule

// File: rtl/buffer_read_scheduler.sv
// Shares one bank read port among NUM_REQ burst requesters: round-robin grant,
// one address per cycle, tagged returns routed back to the owning requester.
module buffer_read_scheduler
    import buffer_sched_pkg::*;
#(
    parameter int NUM_REQ           = 3,
    parameter int BUFFER_ADDR_WIDTH = 11,
    parameter int BUFFER_DATA_WIDTH = 512,
    parameter int LEN_WIDTH         = 12,
    parameter int READ_LATENCY      = 4
) (
    input  logic                                   clk,
    input  logic                                   rst_n,
    input  logic [NUM_REQ-1:0]                     req_valid,
    output logic [NUM_REQ-1:0]                     req_ready,
    input  logic [NUM_REQ*BUFFER_ADDR_WIDTH-1:0]   req_base_addr,
    input  logic [NUM_REQ*LEN_WIDTH-1:0]           req_len,
    output logic                                   buf_read_addr_valid,
    output logic [BUFFER_ADDR_WIDTH-1:0]           buf_read_addr,
    input  logic                                   buf_read_data_valid,
    input  logic [BUFFER_DATA_WIDTH-1:0]           buf_read_data,
    output logic [NUM_REQ-1:0]                     rsp_valid,
    output logic                                   rsp_last,
    output logic [BUFFER_DATA_WIDTH-1:0]           rsp_data,
    output logic                                   busy,
    output logic                                   err
);

    localparam int AW = BUFFER_ADDR_WIDTH;
    localparam int LW = LEN_WIDTH;
    localparam int DW = BUFFER_DATA_WIDTH;

    state_t            state_q, state_d;
    logic [ID_W-1:0]   rr_ptr_q, rr_ptr_d;
    logic [ID_W-1:0]   owner_q, owner_d;
    logic [AW-1:0]     base_q, base_d;
    logic [LW-1:0]     len_q, len_d;
    logic [LW-1:0]     off_q, off_d;

    logic [NUM_REQ-1:0] arb_grant;
    logic [ID_W-1:0]    arb_idx;
    logic               arb_any;
    logic [AW-1:0]      sel_base;
    logic [LW-1:0]      sel_len;
    logic               issue_last;

    rr_arbiter #(.NUM_REQ(NUM_REQ)) u_arb (
        .req_i   (req_valid),
        .ptr_i   (rr_ptr_q),
        .grant_o (arb_grant),
        .idx_o   (arb_idx),
        .any_o   (arb_any)
    );

    assign sel_base            = req_base_addr[int'(arb_idx)*AW +: AW];
    assign sel_len             = req_len[int'(arb_idx)*LW +: LW];
    assign issue_last          = (off_q == len_q - LW'(1));
    assign buf_read_addr_valid = (state_q == ISSUE);
    assign buf_read_addr       = buf_read_addr_valid ? base_q + AW'(off_q) : '0;

    always_comb begin
        state_d   = state_q;
        rr_ptr_d  = rr_ptr_q;
        owner_d   = owner_q;
        base_d    = base_q;
        len_d     = len_q;
        off_d     = off_q;
        req_ready = '0;
        case (state_q)
            IDLE: begin
                if (arb_any) begin
                    req_ready = arb_grant;
                    owner_d   = arb_idx;
                    base_d    = sel_base;
                    len_d     = sel_len;
                    off_d     = '0;
                    rr_ptr_d  = (arb_idx == ID_W'(NUM_REQ - 1)) ? '0 : arb_idx + ID_W'(1);
                    // A zero-length burst is acknowledged but never issued.
                    if (sel_len != '0) state_d = ISSUE;
                end
            end
            ISSUE: begin
                if (issue_last) begin
                    state_d = IDLE;
                    off_d   = '0;
                end else begin
                    off_d = off_q + LW'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            rr_ptr_q <= '0;
            owner_q  <= '0;
            base_q   <= '0;
            len_q    <= '0;
            off_q    <= '0;
        end else begin
            state_q  <= state_d;
            rr_ptr_q <= rr_ptr_d;
            owner_q  <= owner_d;
            base_q   <= base_d;
            len_q    <= len_d;
            off_q    <= off_d;
        end
    end

    tag_t tag_q [READ_LATENCY];
    tag_t tag_push;
    tag_t head;
    logic tag_any_vld;

    always_comb begin
        tag_push.vld  = buf_read_addr_valid;
        tag_push.id   = owner_q;
        tag_push.last = buf_read_addr_valid & issue_last;
    end

    assign head = tag_q[READ_LATENCY-1];

    // NOTE: this small array is reset, unlike a data RAM, because a stale vld
    // bit would fabricate a response or a false error after reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < READ_LATENCY; i++) tag_q[i] <= '0;
        end else begin
            tag_q[0] <= tag_push;
            for (int i = 1; i < READ_LATENCY; i++) tag_q[i] <= tag_q[i-1];
        end
    end

    always_comb begin
        tag_any_vld = 1'b0;
        for (int i = 0; i < READ_LATENCY; i++) tag_any_vld = tag_any_vld | tag_q[i].vld;
    end

    assign busy = (state_q == ISSUE) | tag_any_vld;

    logic [MAX_REQ-1:0] head_oh;
    logic               id_ok;
    logic               rsp_fire;
    logic [NUM_REQ-1:0] rsp_valid_q;
    logic               rsp_last_q;
    logic [DW-1:0]      rsp_data_q;
    logic               err_q;

    assign head_oh  = onehot(head.id);
    assign id_ok    = ~|(head_oh >> NUM_REQ);
    assign rsp_fire = buf_read_data_valid & head.vld & id_ok;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rsp_valid_q <= '0;
            rsp_last_q  <= 1'b0;
            rsp_data_q  <= '0;
            err_q       <= 1'b0;
        end else begin
            rsp_valid_q <= rsp_fire ? head_oh[NUM_REQ-1:0] : '0;
            rsp_last_q  <= rsp_fire & head.last;
            rsp_data_q  <= rsp_fire ? buf_read_data : '0;
            err_q       <= err_q | (buf_read_data_valid != head.vld);
        end
    end

    assign rsp_valid = rsp_valid_q;
    assign rsp_last  = rsp_last_q;
    assign rsp_data  = rsp_data_q;
    assign err       = err_q;

endmodule
